req_pair_arbiter: RTL and testbench

- Two-requester round-robin arbiter that shares one resource between req1 and req2.
- Sequences the resource through IDLE, REQ (arbitration) and GRANT phases, and enforces a maximum hold time per grant.
- Includes a built-in protocol monitor. It flags the case where the arbiter is in REQ while neither request is asserted, timestamps the event, and reports it a fixed number of cycles later.

---
 rtl/req_pair_arbiter_if.sv | 23 ++
 rtl/req_pair_arbiter.sv | 120 ++++++++++++
 tb/tb_req_pair_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/req_pair_arbiter_if.sv
// rtl/req_pair_arbiter_if.sv - request/grant and violation-report signals of req_pair_arbiter
interface req_pair_arbiter_if #(
  parameter int TW = 16
);
  logic          req1;
  logic          req2;
  logic          gnt1;
  logic          gnt2;
  logic          in_req;
  logic          viol_pulse;
  logic [TW-1:0] viol_time;
  logic          viol_ovf;

  modport master (
    output req1, req2,
    input  gnt1, gnt2, in_req, viol_pulse, viol_time, viol_ovf
  );

  modport slave (
    input  req1, req2,
    output gnt1, gnt2, in_req, viol_pulse, viol_time, viol_ovf
  );
endinterface

// File: rtl/req_pair_arbiter.sv
// rtl/req_pair_arbiter.sv - two-requester round-robin arbiter with hold limit and withdrawn-request monitor
module req_pair_arbiter #(
  parameter int MAX_HOLD   = 8,
  parameter int REPORT_DLY = 5,
  parameter int TW         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  req_pair_arbiter_if.slave bus
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int DW = $clog2(REPORT_DLY + 1);

  typedef enum logic [1:0] {IDLE, REQ, GRANT} state_e;

  state_e        state_q, state_d;
  logic          gnt1_q, gnt1_d;
  logic          gnt2_q, gnt2_d;
  logic          last_owner_q, last_owner_d;  // 0: requester 1, 1: requester 2
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [TW-1:0] stamp_q, stamp_d;
  logic [TW-1:0] viol_time_q, viol_time_d;
  logic [DW-1:0] timer_q, timer_d;
  logic          ovf_q, ovf_d;
  logic          viol_evt;
  logic          fire;
  logic          owner_req;

  assign fire      = (timer_q == DW'(1));
  assign owner_req = gnt1_q ? bus.req1 : bus.req2;

  always_comb begin
    state_d      = state_q;
    gnt1_d       = 1'b0;
    gnt2_d       = 1'b0;
    last_owner_d = last_owner_q;
    hold_cnt_d   = '0;
    viol_evt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req1 || bus.req2) state_d = REQ;
      end
      REQ: begin
        // on a tie requester 1 wins unless it owned the previous grant
        if (bus.req1 && (!bus.req2 || last_owner_q)) begin
          state_d = GRANT;
          gnt1_d  = 1'b1;
        end else if (bus.req2) begin
          state_d = GRANT;
          gnt2_d  = 1'b1;
        end else begin
          state_d  = IDLE;
          viol_evt = 1'b1;
        end
      end
      GRANT: begin
        if (!owner_req || (hold_cnt_q == HW'(MAX_HOLD - 1))) begin
          state_d      = IDLE;
          last_owner_d = gnt2_q;
        end else begin
          gnt1_d     = gnt1_q;
          gnt2_d     = gnt2_q;
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cyc_cnt_d   = cyc_cnt_q + TW'(1);
    timer_d     = (timer_q != '0) ? timer_q - DW'(1) : '0;
    stamp_d     = stamp_q;
    ovf_d       = ovf_q;
    viol_time_d = fire ? stamp_q : viol_time_q;
    // a report firing this cycle no longer counts as pending
    if (viol_evt) begin
      if (timer_q > DW'(1)) begin
        ovf_d = 1'b1;
      end else begin
        stamp_d = cyc_cnt_q;
        timer_d = DW'(REPORT_DLY);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt1_q       <= 1'b0;
      gnt2_q       <= 1'b0;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
      cyc_cnt_q    <= '0;
      stamp_q      <= '0;
      viol_time_q  <= '0;
      timer_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt1_q       <= gnt1_d;
      gnt2_q       <= gnt2_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      stamp_q      <= stamp_d;
      viol_time_q  <= viol_time_d;
      timer_q      <= timer_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.gnt1       = gnt1_q;
  assign bus.gnt2       = gnt2_q;
  assign bus.in_req     = (state_q == REQ);
  assign bus.viol_pulse = fire;
  assign bus.viol_time  = fire ? stamp_q : viol_time_q;
  assign bus.viol_ovf   = ovf_q;
endmodule

// File: tb/tb_req_pair_arbiter.sv
// tb/tb_req_pair_arbiter.sv - randomized and directed checks of req_pair_arbiter against a cycle-level model
module tb_req_pair_arbiter;
  localparam int MAX_HOLD   = 8;
  localparam int REPORT_DLY = 5;
  localparam int TW         = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  req_pair_arbiter_if #(.TW(TW)) bus_if ();

  req_pair_arbiter #(
    .MAX_HOLD  (MAX_HOLD),
    .REPORT_DLY(REPORT_DLY),
    .TW        (TW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  // model: phase 0 idle, 1 arbitrating, 2 granted; reports kept as absolute fire cycles
  typedef struct {
    int fire;
    int stamp;
  } rpt_t;

  int   m_phase, m_owner, m_held, m_last, m_cyc, m_last_time;
  bit   m_ovf;
  rpt_t rq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, m_cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_held = 0; m_last = 2;
    m_cyc = 0; m_last_time = 0; m_ovf = 1'b0;
    rq.delete();
  endtask

  task automatic compare_outputs();
    bit ep;
    int et;
    ep = 1'b0;
    et = m_last_time;
    if (rq.size() > 0) begin
      if (rq[0].fire == m_cyc) begin
        ep = 1'b1;
        et = rq[0].stamp;
      end
    end
    check("gnt1", bus_if.gnt1, (m_phase == 2 && m_owner == 1));
    check("gnt2", bus_if.gnt2, (m_phase == 2 && m_owner == 2));
    check("in_req", bus_if.in_req, (m_phase == 1));
    check("viol_pulse", bus_if.viol_pulse, ep);
    check("viol_time", bus_if.viol_time, et);
    check("viol_ovf", bus_if.viol_ovf, m_ovf);
  endtask

  task automatic model_advance(input bit r1, input bit r2);
    int win;
    if (rq.size() > 0) begin
      if (rq[0].fire == m_cyc) begin
        m_last_time = rq[0].stamp;
        void'(rq.pop_front());
      end
    end
    case (m_phase)
      0: if (r1 || r2) m_phase = 1;
      1: begin
        if (r1 && r2)  win = (m_last == 1) ? 2 : 1;
        else if (r1)   win = 1;
        else if (r2)   win = 2;
        else           win = 0;
        if (win != 0) begin
          m_phase = 2; m_owner = win; m_held = 0;
        end else begin
          m_phase = 0;
          if (rq.size() > 0) m_ovf = 1'b1;
          else rq.push_back('{fire: m_cyc + REPORT_DLY, stamp: m_cyc % (1 << TW)});
        end
      end
      default: begin
        m_held++;
        if (!(m_owner == 1 ? r1 : r2) || m_held == MAX_HOLD) begin
          m_last = m_owner; m_owner = 0; m_phase = 0;
        end
      end
    endcase
    m_cyc++;
  endtask

  task automatic step(input bit r1, input bit r2);
    @(negedge clk);
    compare_outputs();
    bus_if.req1 = r1;
    bus_if.req2 = r2;
    model_advance(r1, r2);
  endtask

  task automatic post_reset();
    rst_n = 1'b1;
    model_reset();
    compare_outputs();
    bus_if.req1 = 1'b0;
    bus_if.req2 = 1'b0;
    model_advance(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.req1 = 1'b0;
    bus_if.req2 = 1'b0;
    repeat (3) @(negedge clk);
    post_reset();
  endtask

  task automatic async_reset_mid();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt1", bus_if.gnt1, 1'b0);
    check("arst_gnt2", bus_if.gnt2, 1'b0);
    check("arst_in_req", bus_if.in_req, 1'b0);
    check("arst_pulse", bus_if.viol_pulse, 1'b0);
    @(negedge clk);
    @(negedge clk);
    post_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    do_reset();

    // first grant latency
    step(0, 0);
    step(1, 0); step(1, 0);
    check("t1_in_req_c3", bus_if.in_req, 1'b1);
    step(1, 0);
    check("t1_gnt1_c4", bus_if.gnt1, 1'b1);
    check("t1_gnt2_c4", bus_if.gnt2, 1'b0);
    repeat (3) step(1, 0);
    repeat (3) step(0, 0);

    // withdrawn request at cycle 10, reported at cycle 16
    do_reset();
    for (int c = 1; c <= 9; c++) step(0, 0);
    step(1, 0);
    step(0, 0);
    check("t3_in_req_c11", bus_if.in_req, 1'b1);
    for (int c = 12; c <= 16; c++) step(0, 0);
    check("t3_pulse_c16", bus_if.viol_pulse, 1'b1);
    check("t3_time_c16", bus_if.viol_time, 11);
    check("t3_ovf_c16", bus_if.viol_ovf, 1'b0);

    // continuous tie: alternating full-length grants
    repeat (40) step(1, 1);
    repeat (3) step(0, 0);

    // two violations three cycles apart
    step(1, 0); step(0, 0); step(0, 0); step(1, 0); step(0, 0);
    repeat (8) step(0, 0);
    check("t4_ovf_sticky", bus_if.viol_ovf, 1'b1);

    // early release by requester 2, then a tie goes to requester 1
    repeat (4) step(0, 1);
    step(0, 0);
    step(0, 0);
    repeat (3) step(1, 1);
    check("t5_tie_gnt1", bus_if.gnt1, 1'b1);
    repeat (3) step(0, 0);

    // asynchronous reset mid-grant with a report pending
    do_reset();
    step(1, 0); step(0, 0);
    repeat (3) step(1, 0);
    async_reset_mid();
    step(1, 0); step(0, 0);
    for (int c = 3; c <= 7; c++) step(0, 0);
    check("t6_restamp_pulse", bus_if.viol_pulse, 1'b1);
    check("t6_restamp_time", bus_if.viol_time, 2);
    check("t6_ovf_cleared", bus_if.viol_ovf, 1'b0);

    // randomized segments with varying request density
    for (int seg = 0; seg < 12; seg++) begin
      case (seg % 4)
        0: p = 30;
        1: p = 60;
        2: p = 90;
        default: p = 98;
      endcase
      for (int i = 0; i < 250; i++)
        step($urandom_range(99) < p, $urandom_range(99) < p);
      if (seg % 4 == 3) async_reset_mid();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
